mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between instruction fetch (IF) and the load/store data path (DM) of the RISC-V core.
- Runs a req/gnt handshake toward each requester and a req/ready handshake toward a variable-latency memory.
- Has one outstanding memory transaction at a time.
- Arbitration uses fixed DM priority plus a starvation guard, so fetch always makes progress.

Parameters:
- ADDR_WIDTH, 32, width of all address buses
- DATA_WIDTH, 32, width of all data buses
- STARVE_LIMIT, 4, max consecutive DM grants while if_req is pending (>=1)
- MEM_TIMEOUT, 16, cycles without mem_ready before abort (used only with MEM_ARB_TIMEOUT_EN, >=1)

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous reset, active low
- if_req  in  1  fetch request, held until if_gnt
- if_addr  in  ADDR_WIDTH  fetch address
- if_gnt  out  1  one-cycle pulse, fetch request accepted
- if_rvalid  out  1  one-cycle pulse, fetch data valid
- if_rdata  out  DATA_WIDTH  fetch data, valid with if_rvalid
- if_err  out  1  fetch aborted by timeout, valid with if_rvalid
- dm_req  in  1  data request, held until dm_gnt
- dm_we  in  1  1=store, 0=load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  DATA_WIDTH  store data
- dm_gnt  out  1  one-cycle pulse, data request accepted
- dm_rvalid  out  1  one-cycle pulse, load data valid / store complete
- dm_rdata  out  DATA_WIDTH  load data (0 for stores)
- dm_err  out  1  data access aborted by timeout, valid with dm_rvalid
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ready  in  1  memory done; read data valid this cycle
- mem_rdata  in  DATA_WIDTH  memory read data
- busy  out  1  high while not IDLE

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0; FSM goes to IDLE; starve_cnt=0.
  - Any in-flight transaction is dropped; no rvalid is produced for it.
- FSM states: IDLE, IF_BUSY, DM_BUSY. All outputs are registered.
- Arbitration in IDLE, evaluated each cycle:
  - Grant DM if dm_req=1 and (if_req=0 or starve_cnt<STARVE_LIMIT).
  - Otherwise grant IF if if_req=1.
  - Otherwise stay in IDLE.
- On grant at edge T:
  - Pulse the matching *_gnt high for cycle T+1.
  - Latch addr/we/wdata (IF: we=0, wdata=0) into mem_* outputs.
  - Go to IF_BUSY or DM_BUSY; mem_req=1 from T+1.
- starve_cnt:
  - Increments on each DM grant while if_req=1, saturating at STARVE_LIMIT.
  - Clears on IF grant, or on a DM grant while if_req=0.
  - Width is $clog2(STARVE_LIMIT+1).
- BUSY states:
  - mem_req and mem_* stay stable until mem_ready=1.
  - On the edge where mem_ready=1: capture mem_rdata (forced to 0 for stores) into the granted requester's rdata, pulse its rvalid the next cycle, drop mem_req, return to IDLE.
- Latency:
  - Grant pulse at T+1; with mem_ready first high in cycle T+1+k (k>=0), rvalid is at T+2+k.
  - The next grant pulse is possible at T+3+k (arbitration is evaluated in IDLE at T+2+k).
  - Zero-wait memory: 3 cycles request-to-rvalid, back-to-back grants every 2 cycles.
- Requester side:
  - Deasserting a request before its gnt withdraws it.
  - A request still high after rvalid is treated as a new request.
  - Inputs are ignored while BUSY, except mem_ready/mem_rdata.
- mem_ready outside BUSY states is ignored.
- rdata outputs hold their last value between rvalid pulses.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on each grant and increments every BUSY cycle with mem_ready=0.
  - On reaching MEM_TIMEOUT: drop mem_req, pulse the owner's rvalid with err=1 and rdata=0, return to IDLE.
  - The timeout does not change starve_cnt.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - if_err and dm_err are tied to 0.

Test Plan:
1. if_req=1, if_addr=0x100, mem_ready after 2 cycles with rdata=0x00500093 -> if_gnt at T+1, mem_addr=0x100 with mem_we=0, if_rvalid=1 with if_rdata=0x00500093 at T+4, busy low at T+4.
2. dm_req=1, dm_we=1, dm_addr=0x200, dm_wdata=0xDEADBEEF, zero-wait memory -> mem_we=1, mem_wdata=0xDEADBEEF, dm_rvalid pulse with dm_rdata=0, if_* outputs idle.
3. if_req and dm_req rise in the same cycle, both held, STARVE_LIMIT=4 -> grants DM,DM,DM,DM,IF, then DM again; starve_cnt returns to 0 after the IF grant.
4. dm_req held, if_req=0, 10 zero-wait transactions -> all granted to DM, starve_cnt stays 0, back-to-back grants every 2 cycles.
5. reset_n pulsed low while in DM_BUSY with mem_ready=0 -> all outputs 0 immediately (async), no dm_rvalid after release, next request arbitrated normally from IDLE.
6. MEM_ARB_TIMEOUT_EN defined, MEM_TIMEOUT=16, mem_ready held 0 on an IF read -> mem_req drops after 16 BUSY cycles, if_rvalid=1 with if_err=1 and if_rdata=0. Macro undefined -> still BUSY after 100 cycles, if_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the data path.
// Optional watchdog abort on stalled memory: define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MEM_TIMEOUT  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_gnt,
  output logic                  if_rvalid,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_err,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  output logic                  dm_gnt,
  output logic                  dm_rvalid,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  dm_err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY} state_t;

  state_t                state_q, state_d;
  logic [SC_W-1:0]       starve_q, starve_d;
  logic                  grant_dm, grant_if, timeout_hit;
  logic                  if_gnt_d, dm_gnt_d, if_rvalid_d, dm_rvalid_d, if_err_d, dm_err_d;
  logic                  mem_req_d, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_d, if_rdata_d, dm_rdata_d;

  assign grant_dm = dm_req && (!if_req || (starve_q < SC_W'(STARVE_LIMIT)));
  assign grant_if = if_req && !grant_dm;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0] to_cnt;

  // Clearing while IDLE is equivalent to clearing on each grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            to_cnt <= '0;
    else if (state_q == IDLE) to_cnt <= '0;
    else if (!mem_ready)     to_cnt <= to_cnt + TO_W'(1);
  end

  assign timeout_hit = (state_q != IDLE) && !mem_ready && (to_cnt == TO_W'(MEM_TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      if_gnt    <= 1'b0;
      dm_gnt    <= 1'b0;
      if_rvalid <= 1'b0;
      dm_rvalid <= 1'b0;
      if_err    <= 1'b0;
      dm_err    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      if_gnt    <= if_gnt_d;
      dm_gnt    <= dm_gnt_d;
      if_rvalid <= if_rvalid_d;
      dm_rvalid <= dm_rvalid_d;
      if_err    <= if_err_d;
      dm_err    <= dm_err_d;
      if_rdata  <= if_rdata_d;
      dm_rdata  <= dm_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_dm)      state_d = DM_BUSY;
        else if (grant_if) state_d = IF_BUSY;
      end
      IF_BUSY, DM_BUSY: begin
        if (mem_ready || timeout_hit) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    starve_d    = starve_q;
    if_gnt_d    = 1'b0;
    dm_gnt_d    = 1'b0;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    dm_err_d    = 1'b0;
    if_rdata_d  = if_rdata;
    dm_rdata_d  = dm_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          dm_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req)                                starve_d = '0;
          else if (starve_q != SC_W'(STARVE_LIMIT)) starve_d = starve_q + SC_W'(1);
        end else if (grant_if) begin
          if_gnt_d    = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      IF_BUSY: begin
        if (mem_ready) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
          mem_req_d   = 1'b0;
        end else if (timeout_hit) begin
          if_rvalid_d = 1'b1;
          if_err_d    = 1'b1;
          if_rdata_d  = '0;
          mem_req_d   = 1'b0;
        end
      end
      DM_BUSY: begin
        if (mem_ready) begin
          dm_rvalid_d = 1'b1;
          dm_rdata_d  = mem_we ? '0 : mem_rdata;
          mem_req_d   = 1'b0;
        end else if (timeout_hit) begin
          dm_rvalid_d = 1'b1;
          dm_err_d    = 1'b1;
          dm_rdata_d  = '0;
          mem_req_d   = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single transactions plus
// hand-written grant-sequence, async-reset and memory-stall sequences.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic          if_gnt, if_rvalid, if_err, dm_gnt, dm_rvalid, dm_err;
  logic          mem_req, mem_we, busy;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;
  logic [DW-1:0] last_if = '0;
  logic [DW-1:0] last_dm = '0;

  mem_port_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .STARVE_LIMIT(4),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          ifr;
    logic [AW-1:0] ia;
    logic          dmr;
    logic          we;
    logic [AW-1:0] da;
    logic [DW-1:0] wd;
    int unsigned   k;
    logic [DW-1:0] rd;
    logic          exp_dm;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " if_gnt"}, if_gnt, 0);       check({tag, " dm_gnt"}, dm_gnt, 0);
    check({tag, " if_rvalid"}, if_rvalid, 0); check({tag, " dm_rvalid"}, dm_rvalid, 0);
    check({tag, " if_rdata"}, if_rdata, 0);   check({tag, " dm_rdata"}, dm_rdata, 0);
    check({tag, " if_err"}, if_err, 0);       check({tag, " dm_err"}, dm_err, 0);
    check({tag, " mem_req"}, mem_req, 0);     check({tag, " mem_we"}, mem_we, 0);
    check({tag, " mem_addr"}, mem_addr, 0);   check({tag, " mem_wdata"}, mem_wdata, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  // Starts in IDLE with requests low; returns in IDLE one cycle after rvalid.
  task automatic run_vec(input vec_t v, input string tag);
    if_req = v.ifr; if_addr = v.ia; dm_req = v.dmr; dm_we = v.we;
    dm_addr = v.da; dm_wdata = v.wd; mem_ready = 1'b0;
    tick();
    check({tag, " if_gnt"}, if_gnt, !v.exp_dm);
    check({tag, " dm_gnt"}, dm_gnt, v.exp_dm);
    check({tag, " mem_req"}, mem_req, 1);
    check({tag, " busy"}, busy, 1);
    check({tag, " mem_addr"}, mem_addr, v.exp_dm ? v.da : v.ia);
    check({tag, " mem_we"}, mem_we, v.exp_dm ? v.we : 1'b0);
    check({tag, " mem_wdata"}, mem_wdata, v.exp_dm ? v.wd : 32'h0);
    if_req = 1'b0; dm_req = 1'b0;
    for (int unsigned i = 0; i < v.k; i++) begin
      mem_rdata = 32'hBAD0_0000 | i;
      tick();
      check({tag, " wait rvalid"}, {if_rvalid, dm_rvalid}, 0);
      check({tag, " wait gnt"}, {if_gnt, dm_gnt}, 0);
      check({tag, " wait mem_req"}, mem_req, 1);
    end
    mem_ready = 1'b1; mem_rdata = v.rd;
    tick();
    mem_ready = 1'b0;
    check({tag, " if_rvalid"}, if_rvalid, !v.exp_dm);
    check({tag, " dm_rvalid"}, dm_rvalid, v.exp_dm);
    check({tag, " err"}, {if_err, dm_err}, 0);
    check({tag, " busy done"}, busy, 0);
    check({tag, " mem_req done"}, mem_req, 0);
    if (v.exp_dm) begin
      check({tag, " dm_rdata"}, dm_rdata, v.exp_rdata);
      check({tag, " if_rdata held"}, if_rdata, last_if);
      last_dm = v.exp_rdata;
    end else begin
      check({tag, " if_rdata"}, if_rdata, v.exp_rdata);
      check({tag, " dm_rdata held"}, dm_rdata, last_dm);
      last_if = v.exp_rdata;
    end
    tick();
    check({tag, " rvalid pulse"}, {if_rvalid, dm_rvalid}, 0);
  endtask

  // Holds requests with a zero-wait memory and records the order of n grants.
  task automatic grant_seq(input logic ifr, input int unsigned n, input string exp_pat, input string tag);
    string       pat = "";
    int unsigned c = 0, last_c = 0, got = 0;
    logic        ok = 1'b1;
    if_req = ifr; if_addr = 32'h400; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h800;
    mem_ready = 1'b1; mem_rdata = 32'h0000_1234;
    while (got < n && c < 100) begin
      tick();
      c++;
      if (if_gnt && dm_gnt) ok = 1'b0;
      if (if_gnt || dm_gnt) begin
        if (dm_gnt) pat = {pat, "D"};
        else        pat = {pat, "I"};
        if (got > 0 && (c - last_c) != 2) ok = 1'b0;
        last_c = c;
        got++;
      end
    end
    if_req = 1'b0; dm_req = 1'b0;
    n_vec++;
    if (pat != exp_pat) begin
      n_fail++;
      $display("FAIL %s order: got %s expected %s", tag, pat, exp_pat);
    end
    check({tag, " spacing"}, ok, 1);
    tick(); tick();
    mem_ready = 1'b0;
    tick();
    check({tag, " idle after"}, busy, 0);
    last_if = if_rdata;
    last_dm = dm_rdata;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    vecs[0] = '{1'b1, 32'h100, 1'b0, 1'b0, 32'h0,   32'h0,        2, 32'h0050_0093, 1'b0, 32'h0050_0093};
    vecs[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 0, 32'h1234_5678, 1'b1, 32'h0};
    vecs[2] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h300, 32'h0,        1, 32'hCAFE_F00D, 1'b1, 32'hCAFE_F00D};
    vecs[3] = '{1'b1, 32'h104, 1'b1, 1'b0, 32'h304, 32'h0,        0, 32'h1111_1111, 1'b1, 32'h1111_1111};
    vecs[4] = '{1'b1, 32'h108, 1'b0, 1'b0, 32'h0,   32'h0,        3, 32'hA5A5_A5A5, 1'b0, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 32'h10C, 1'b1, 1'b1, 32'h308, 32'h55AA_55AA, 1, 32'hFFFF_FFFF, 1'b1, 32'h0};
    vecs[6] = '{1'b0, 32'h0,   1'b1, 1'b0, 32'h30C, 32'h0,        0, 32'h0BAD_CAFE, 1'b1, 32'h0BAD_CAFE};

    reset_n = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    #3;
    check_all_zero("reset");
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    grant_seq(1'b0, 10, "DDDDDDDDDD", "dm_only");
    grant_seq(1'b1, 6, "DDDDID", "starve");
    grant_seq(1'b1, 4, "DDDI", "starve_resume");

    // Async reset in the middle of a stalled data access.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h440; mem_ready = 1'b0;
    tick();
    check("rst pre dm_gnt", dm_gnt, 1);
    dm_req = 1'b0;
    tick(); tick();
    check("rst pre busy", busy, 1);
    #2 reset_n = 1'b0;
    #1 check_all_zero("async_rst");
    mem_ready = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (dm_rvalid || if_rvalid || busy) seen = 1'b1;
    end
    check("rst no rvalid", seen, 0);
    mem_ready = 1'b0;
    last_if = '0; last_dm = '0;
    run_vec('{1'b1, 32'h180, 1'b0, 1'b0, 32'h0, 32'h0, 0, 32'h0000_0013, 1'b0, 32'h0000_0013}, "post_rst");

    // Memory never answers.
    if_req = 1'b1; if_addr = 32'h500; mem_ready = 1'b0;
    tick();
    check("stall if_gnt", if_gnt, 1);
    if_req = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
    begin
      int unsigned c = 0;
      while (!if_rvalid && c < 40) begin
        tick();
        c++;
      end
      check("timeout cycles", c, TO);
      check("timeout rvalid", if_rvalid, 1);
      check("timeout err", if_err, 1);
      check("timeout rdata", if_rdata, 0);
      check("timeout busy", busy, 0);
      check("timeout mem_req", mem_req, 0);
    end
`else
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (if_rvalid || if_err || !busy || !mem_req) seen = 1'b1;
    end
    check("stall still busy", seen, 0);
    mem_ready = 1'b1; mem_rdata = 32'h0000_0777;
    tick();
    mem_ready = 1'b0;
    check("stall rvalid", if_rvalid, 1);
    check("stall rdata", if_rdata, 32'h0000_0777);
    check("stall err", if_err, 0);
`endif
    tick();
    check("final idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
